switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Input conditioning stage between the board DIP switches and the lab's hex-display/LED top module. Each switch bit passes through a two-flop synchronizer and a per-bit stability counter. The stable, glitch-free value is presented as `s[3:0]`, the switch bus the seven-segment decoder and LED logic consume. An optional one-cycle strobe flags every accepted change.

## Interface
Parameters:
- `WIDTH`, default 4: number of switch bits.
- `STABLE_CYCLES`, default 480000: consecutive cycles a synchronized bit must differ from its output before the output is updated. This is 10 ms at 48 MHz. Legal range is 1 to 2^24.

Ports:
- `clk`, input, 1: single clock, rising-edge, on-chip oscillator domain.
- `reset`, input, 1: asynchronous, active-low reset. Asserted when 0. Clears all state immediately.
- `sw_raw`, input, `WIDTH`: raw, asynchronous, bouncing switch pins.
- `s`, output, `WIDTH`: debounced switch value. Registered.
- `changed`, output, 1: one-cycle pulse when any bit of `s` updates. Registered. Present only under the macro; see Configuration.

## Operation
- Synchronizer:
  - Per-bit `sync1 <= sw_raw`, `sync2 <= sync1`.
  - No logic is placed between `sync1` and `sync2`.
- Counter:
  - Each bit has an independent counter `cnt[i]` of width `$clog2(STABLE_CYCLES+1)`.
- Per-bit rules, evaluated each rising edge:
  - If `sync2[i] == s[i]`: set `cnt[i] <= 0`. Any bounce restarts qualification.
  - Else if `cnt[i] == STABLE_CYCLES-1`: set `s[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i] + 1`.
  - The counter never exceeds `STABLE_CYCLES-1`. No wrap-around is possible.
- Per-bit state is implicit in two conditions:
  - IDLE: `cnt == 0`, `sync2 == s`.
  - QUALIFY: `sync2 != s`.
  - IDLE→QUALIFY on mismatch.
  - QUALIFY→IDLE on match (output unchanged) or on terminal count (output toggles).
- `changed <= |(update mask)`. Simultaneous updates on several bits in the same edge produce exactly one pulse.
- Reset values: `sync1`, `sync2`, `s`, all `cnt` are 0, and `changed` is 0.
- Reset mid-qualification discards the partial count.
- After reset release with switches already on, the bits qualify normally from 0, and one `changed` pulse follows.

## Timing
- Let E0 be the first rising edge that samples a new stable `sw_raw` value into `sync1`.
  - `sync2` updates at E0+1.
  - `s` and `changed` update at E0+`STABLE_CYCLES`+1, i.e. the (`STABLE_CYCLES`+2)th edge counting E0.
- `changed` is high for exactly one cycle, aligned with the first cycle `s` shows the new value.
- A bounce of any length shorter than `STABLE_CYCLES` cycles in `sync2` produces no output change.
- A bounce returning to the old value resets the count. The latency is then measured from the last transition.
- Bits are independent. Different bits qualify on different edges and produce separate `changed` pulses.
- `reset` assertion clears outputs asynchronously, with no clock required. Deassertion is assumed synchronous to `clk` by the board-level reset synchronizer.

## Configuration
- `SWITCH_DEBOUNCE_STROBE_EN`:
  - When defined, the `changed` port, its register and the update-mask OR are compiled in, with behaviour as above.
  - When undefined, the `changed` port is absent from the port list. `s` behaviour is identical in both builds.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `WIDTH`=4 in simulation.
- Reset: hold `reset`=0 with `sw_raw`=4'b1111 → `s`=0 and `changed`=0 while held, including between clock edges. Release → `s`=4'b1111 at edge 6 after release, with one `changed` pulse.
- Clean step: `sw_raw` 0→4'b0101 before edge E0 → `s`=0 through E0+4. `s`=4'b0101 and `changed`=1 after E0+5. `changed`=0 after E0+6.
- Bounce: bit 0 toggles 1,0,1,0,1 every 2 cycles, then holds 1 → no `s` change during the bounce. `s[0]`=1 exactly 6 edges after the final transition edge.
- Short glitch: a 3-cycle pulse of 1 on bit 3 from rest → `s` stays 0 and `changed` never asserts.
- Simultaneous and staggered updates:
  - Bits 1 and 2 change on the same edge → a single one-cycle `changed` pulse.
  - Bit 1 changes 2 cycles after bit 2 → two distinct pulses 2 cycles apart.
- Mid-qualification reset: assert `reset` 2 edges after a change on bit 0 → `s`=0. The full 6-edge latency applies after release.

Source files
------------

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Conditions the raw DIP-switch pins for the hex-display / LED logic. Each
// switch bit goes through a two-flop synchronizer and then its own stability
// counter. The output bit follows the synchronized bit only after the two have
// disagreed for STABLE_CYCLES consecutive clocks. A bounce back to the current
// output value before then restarts the qualification.
//
// Optional feature (macro SWITCH_DEBOUNCE_STROBE_EN):
//   When defined, a registered one-cycle 'changed' strobe is added. It fires
//   whenever any output bit updates. Several bits updating on the same edge
//   give a single pulse. When the macro is undefined the port does not exist.
//
// Parameters:
//   WIDTH          number of switch bits
//   STABLE_CYCLES  consecutive mismatching cycles needed before an update
//                  (1 .. 2**24; default 480000 = 10 ms at 48 MHz)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset; clears all state
//   sw_raw   raw asynchronous switch pins
//   s        debounced switch value (registered)
//   changed  one-cycle update strobe (registered, only with the macro)
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 480000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] s
`ifdef SWITCH_DEBOUNCE_STROBE_EN
  ,
  output logic             changed
`endif
);

  // Counter holds 0 .. STABLE_CYCLES-1, so this width always suffices.
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] TERM_CNT = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] s_next;

  // Plain two-flop synchronizer. Nothing sits between the two stages, so the
  // first flop gets a full clock period to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync2_stage_in(sync1_reg);
    end
  end

  function automatic logic [WIDTH-1:0] sync2_stage_in(input logic [WIDTH-1:0] v);
    return v;
  endfunction

  // Per-bit qualification. The per-bit state is implicit:
  //   IDLE    : sync2 == s (counter held at 0)
  //   QUALIFY : sync2 != s (counter runs)
  // Terminal count copies sync2 into s, which drops the bit back to IDLE.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          s_bit_next;

      always_comb begin
        cnt_next   = cnt_reg;
        s_bit_next = s_reg[gi];
        if (sync2_reg[gi] == s_reg[gi]) begin
          // Back at the output value: any partial qualification is discarded.
          cnt_next = '0;
        end else if (cnt_reg == TERM_CNT) begin
          s_bit_next = sync2_reg[gi];
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign s_next[gi] = s_bit_next;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_reg <= '0;
    end else begin
      s_reg <= s_next;
    end
  end

  assign s = s_reg;

`ifdef SWITCH_DEBOUNCE_STROBE_EN
  logic [WIDTH-1:0] upd_mask;
  logic             changed_reg;

  // A bit updates exactly when its next value differs from its current one.
  assign upd_mask = s_next ^ s_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= |upd_mask;
    end
  end

  assign changed = changed_reg;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Drives directed scenarios and randomized switch activity into the debouncer
// (WIDTH=4, STABLE_CYCLES=4) and checks every cycle against a reference model.
// The model keeps the raw pin value delayed by two samples and a sliding
// window of the last STABLE_CYCLES synchronized samples per bit; a bit flips
// when every sample in its window differs from its current output value.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int W  = 4;
  localparam int SC = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] s;
  logic         changed;

  int n_tests;
  int n_fail;

`ifdef SWITCH_DEBOUNCE_STROBE_EN
  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .s       (s),
    .changed (changed)
  );
`else
  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .s      (s)
  );
  assign changed = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [W-1:0] m_p1, m_p2, m_s;
  logic         m_chg;
  logic [W-1:0] m_hist [SC];   // m_hist[k]: synchronized value k edges ago

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_s = '0; m_chg = 1'b0;
    for (int k = 0; k < SC; k++) m_hist[k] = '0;
  endtask

  task automatic model_step(input logic [W-1:0] v);
    logic [W-1:0] flip;
    for (int k = SC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = m_p2;
    flip = '1;
    for (int k = 0; k < SC; k++) flip &= (m_hist[k] ^ m_s);
    m_chg = |flip;
    m_s   = m_s ^ flip;
    m_p2  = m_p1;
    m_p1  = v;
  endtask

  // ---------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply input, let the edge happen, step the model, compare.
  task automatic tick(input logic [W-1:0] v);
    sw_raw = v;
    @(posedge clk);
    model_step(v);
    #1;
    check("s", 32'(s), 32'(m_s));
`ifdef SWITCH_DEBOUNCE_STROBE_EN
    check("changed", 32'(changed), 32'(m_chg));
`endif
  endtask

  // Reset is asserted between edges and checked immediately (no clock needed).
  task automatic apply_reset(input logic [W-1:0] v, input int hold);
    sw_raw = v;
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_s", 32'(s), 32'h0);
    check("rst_async_chg", 32'(changed), 32'h0);
    model_reset();
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("rst_hold_s", 32'(s), 32'h0);
      check("rst_hold_chg", 32'(changed), 32'h0);
    end
    #2;
    reset = 1'b1;
  endtask

  // Hold a value and report the tick (1 = first edge sampling it) on which
  // s first equals want under mask, or 0 if it never does within limit.
  task automatic hold_and_measure(input logic [W-1:0] v, input logic [W-1:0] mask,
                                  input logic [W-1:0] want, input int limit,
                                  output int lat, output int pulses);
    lat = 0;
    pulses = 0;
    for (int i = 1; i <= limit; i++) begin
      tick(v);
      if (changed) pulses++;
      if (lat == 0 && ((s & mask) == want)) lat = i;
    end
  endtask

  int lat, pulses, first_p, second_p;
  logic seen;
  logic [W-1:0] cur;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    sw_raw  = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset with switches already on: qualify from zero after release.
    apply_reset(4'hF, 3);
    hold_and_measure(4'hF, 4'hF, 4'hF, 12, lat, pulses);
    check("rst_release_lat", 32'(lat), 32'd6);
`ifdef SWITCH_DEBOUNCE_STROBE_EN
    check("rst_release_pulses", 32'(pulses), 32'd1);
`endif

    // Return to zero, then clean step to 0101.
    hold_and_measure(4'h0, 4'hF, 4'h0, 10, lat, pulses);
    hold_and_measure(4'h5, 4'hF, 4'h5, 10, lat, pulses);
    check("step_lat", 32'(lat), 32'd6);
`ifdef SWITCH_DEBOUNCE_STROBE_EN
    check("step_pulses", 32'(pulses), 32'd1);
`endif
    hold_and_measure(4'h0, 4'hF, 4'h0, 10, lat, pulses);

    // Bounce on bit 0: 1,0,1,0 each two cycles, then hold 1.
    seen = 1'b0;
    for (int b = 0; b < 4; b++) begin
      tick((b % 2 == 0) ? 4'h1 : 4'h0);
      if (s[0]) seen = 1'b1;
      tick((b % 2 == 0) ? 4'h1 : 4'h0);
      if (s[0]) seen = 1'b1;
    end
    check("bounce_no_change", 32'(seen), 32'd0);
    hold_and_measure(4'h1, 4'h1, 4'h1, 12, lat, pulses);
    check("bounce_lat", 32'(lat), 32'd6);
    hold_and_measure(4'h0, 4'hF, 4'h0, 10, lat, pulses);

    // Three-cycle glitch on bit 3.
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick((i < 3) ? 4'h8 : 4'h0);
      if (s[3] || changed) seen = 1'b1;
    end
    check("glitch_ignored", 32'(seen), 32'd0);

    // Bits 1 and 2 together: one pulse.
    hold_and_measure(4'h6, 4'hF, 4'h6, 12, lat, pulses);
    check("simul_lat", 32'(lat), 32'd6);
`ifdef SWITCH_DEBOUNCE_STROBE_EN
    check("simul_pulses", 32'(pulses), 32'd1);
`endif
    hold_and_measure(4'h0, 4'hF, 4'h0, 10, lat, pulses);

    // Bit 2 first, bit 1 two cycles later: two pulses two cycles apart.
    pulses = 0; first_p = 0; second_p = 0;
    for (int i = 1; i <= 14; i++) begin
      tick((i <= 2) ? 4'h4 : 4'h6);
      if (changed) begin
        pulses++;
        if (first_p == 0) first_p = i; else second_p = i;
      end
    end
    check("stagger_s", 32'(s), 32'h6);
`ifdef SWITCH_DEBOUNCE_STROBE_EN
    check("stagger_pulses", 32'(pulses), 32'd2);
    check("stagger_gap", 32'(second_p - first_p), 32'd2);
`endif
    hold_and_measure(4'h0, 4'hF, 4'h0, 10, lat, pulses);

    // Reset two edges into a qualification on bit 0.
    tick(4'h1);
    tick(4'h1);
    apply_reset(4'h1, 2);
    hold_and_measure(4'h1, 4'hF, 4'h1, 12, lat, pulses);
    check("midq_lat", 32'(lat), 32'd6);

    // Randomized segments of held values with occasional resets.
    cur = 4'h1;
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 40) == 0) apply_reset(cur, $urandom_range(1, 3));
      cur = cur ^ 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 9)) tick(cur);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
